sar_conv_controller: RTL
========================

// Module: sar_conv_controller
// PURPOSE
//   Successive-approximation sequencer for the SAR ADC.
//   - Reads the control register driven by the SPI slave and launches single-shot or continuous conversions.
//   - Drives the sample switch and DAC code, and resolves NBITS from the comparator.
//   - Returns result, busy, EOC pulse and the hardware start-clear strobe to the SPI slave.
// PARAMETERS
//   NBITS          12  conversion resolution; legal range 1..12
//   SAMPLE_CYCLES   4  cycles sample_en is held high; must be >=1
//   SETTLE_CYCLES   2  DAC settle cycles per bit trial; must be >=1
// PORTS
//   clk             in   1      system clock
//   reset_          in   1      asynchronous active-low reset
//   ctrl_reg_in     in   12     control register from SPI slave:
//                               [0]=EN, [1]=START, [2]=CONT, [3]=WAIT_RD; [11:4] ignored
//   eoc_flag_in     in   1      EOC latch state from SPI slave
//   comp_in         in   1      comparator: 1 = Vin >= Vdac; synchronous to clk
//   sample_en       out  1      sample/hold switch enable
//   dac_code        out  NBITS  code driven to capacitive DAC
//   adc_data_out    out  12     last completed result, right-aligned, MSBs zero
//   adc_busy_out    out  1      high while in SAMPLE or CONVERT
//   adc_eoc_pulse   out  1      one-cycle pulse; result valid
//   hw_clear_start  out  1      one-cycle pulse at each launch; clears START and EOC in SPI slave
// BEHAVIOUR
//   Reset: state IDLE; every output is 0; internal result and counters are 0.
//   All outputs are registered.
//   Trigger condition: trig = EN & (START | CONT) & ~(CONT & WAIT_RD & eoc_flag_in).
//   States:
//   - IDLE: if trig is true at edge T, enter SAMPLE at T.
//     hw_clear_start is high, and sample_en and busy are set, for the cycle following T.
//   - SAMPLE:
//     - sample_en=1, dac_code=0, for exactly SAMPLE_CYCLES cycles.
//     - Then go to CONVERT with bit index i=NBITS-1 and result cleared.
//   - CONVERT: for each i, from NBITS-1 down to 0:
//     - dac_code = result | (1<<i), held for SETTLE_CYCLES cycles.
//     - On the last settle cycle, sample comp_in: result[i] = comp_in.
//     - After i=0, go to DONE.
//   - DONE (1 cycle):
//     - adc_data_out = {0, result} is loaded on entry.
//     - adc_eoc_pulse=1 and busy=0 for this cycle.
//     - Exit: if trig is true, go to SAMPLE with a fresh hw_clear_start pulse (back-to-back); otherwise go to IDLE.
//   Latency from the trigger edge T:
//   - busy is high for SAMPLE_CYCLES + NBITS*SETTLE_CYCLES cycles.
//   - DONE occupies cycle T+1+SAMPLE_CYCLES+NBITS*SETTLE_CYCLES.
//   - Defaults: 28 busy cycles, DONE at T+29, continuous period 29 cycles.
//   START bit: the SPI slave clears it within 1 cycle of hw_clear_start.
//   - The controller never samples START during SAMPLE or CONVERT.
//   - START held by SW does not cause a double launch.
//   adc_data_out holds its value until the next DONE.
//   - It stays stable for >=3 cycles after adc_eoc_pulse, which covers the slave's 2-flop edge detect.
//   Abort: EN=0 seen in SAMPLE or CONVERT means:
//   - Go to IDLE on the next edge, with sample_en=0, dac_code=0 and busy=0.
//   - No adc_eoc_pulse; adc_data_out is unchanged.
//   EN=0 seen in DONE: DONE completes normally, then the block goes to IDLE.
//   WAIT_RD=1 in continuous mode: no launch while eoc_flag_in=1.
//   - The launch edge is the first edge that sees eoc_flag_in=0.
//   Reset mid-operation: immediate asynchronous return to reset values.
//   - No pulse is emitted on reset release.
//   Counter width: clog2(max(SAMPLE_CYCLES, SETTLE_CYCLES)) + 1.
//   Bit index width: clog2(NBITS) + 1.
//   No wrap: the index stops at 0 and is reloaded on SAMPLE entry.
// TESTING
//   1. Single-shot: ctrl=0x003, comparator model Vin=0xA5C.
//      -> hw_clear_start pulse at T+1; busy 28 cycles; adc_data_out=0xA5C with eoc pulse at T+29; then IDLE.
//   2. Vin=0x000, then Vin=0xFFF.
//      -> results 0x000 and 0xFFF; dac_code trial sequence 0x800,0x400,... checked per bit.
//   3. Continuous: ctrl=0x005, eoc_flag_in tied 0.
//      -> 4 results spaced exactly 29 cycles apart; hw_clear_start at each launch.
//   4. Continuous with WAIT_RD: ctrl=0x00D, eoc_flag_in=1 for 50 cycles after the first result.
//      -> no launch while eoc_flag_in=1; launch on the first edge after eoc_flag_in falls.
//   5. Abort: EN cleared during CONVERT at bit i=6.
//      -> IDLE next cycle; no eoc pulse; adc_data_out retains its prior value; sample_en, dac_code and busy = 0.
//   6. reset_ low mid-SAMPLE, then released.
//      -> all outputs 0 immediately; with ctrl=0x000 no eoc or hw_clear_start after release.

Source files
------------

// File: rtl/sar_conv_controller.sv
// Successive-approximation sequencer: launches single-shot or continuous conversions,
// drives the sample switch and DAC trial codes, and resolves the result from the comparator.
`timescale 1ns/1ps

module sar_conv_controller #(
    parameter int NBITS         = 12,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [11:0]      ctrl_reg_in,
    input  logic             eoc_flag_in,
    input  logic             comp_in,
    output logic             sample_en,
    output logic [NBITS-1:0] dac_code,
    output logic [11:0]      adc_data_out,
    output logic             adc_busy_out,
    output logic             adc_eoc_pulse,
    output logic             hw_clear_start
);

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(NBITS) + 1;

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_MASK    = NBITS'(1) << (NBITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [NBITS-1:0]   result_reg;

    logic               sample_en_reg;
    logic [NBITS-1:0]   dac_reg;
    logic [11:0]        data_reg;
    logic               busy_reg;
    logic               eoc_reg;
    logic               clear_reg;

    logic               ctrl_en;
    logic               ctrl_start;
    logic               ctrl_cont;
    logic               ctrl_wait_rd;
    logic               trig;
    logic               ctrl_unused;

    logic [NBITS-1:0]   bit_mask;
    logic [NBITS-1:0]   result_next;
    logic [NBITS-1:0]   trial_next;
    logic [11:0]        data_next;
    logic               cnt_done;
    logic               last_bit;

    assign ctrl_en      = ctrl_reg_in[0];
    assign ctrl_start   = ctrl_reg_in[1];
    assign ctrl_cont    = ctrl_reg_in[2];
    assign ctrl_wait_rd = ctrl_reg_in[3];
    assign ctrl_unused  = ^ctrl_reg_in[11:4];

    // In continuous mode with WAIT_RD, hold off until software has read the previous result.
    assign trig = ctrl_en & (ctrl_start | ctrl_cont) & ~(ctrl_cont & ctrl_wait_rd & eoc_flag_in);

    // One-hot mask of the bit currently under trial.
    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit_mask
            assign bit_mask[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign cnt_done    = (cnt_reg == '0);
    assign last_bit    = (idx_reg == '0);
    assign result_next = result_reg | (comp_in ? bit_mask : '0);
    assign trial_next  = result_next | (bit_mask >> 1);

    always_comb begin
        data_next              = '0;
        data_next[NBITS-1:0]   = result_next;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            result_reg    <= '0;
            sample_en_reg <= 1'b0;
            dac_reg       <= '0;
            data_reg      <= '0;
            busy_reg      <= 1'b0;
            eoc_reg       <= 1'b0;
            clear_reg     <= 1'b0;
        end else begin
            clear_reg <= 1'b0;
            eoc_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (trig) begin
                        state_reg     <= ST_SAMPLE;
                        sample_en_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        clear_reg     <= 1'b1;
                        dac_reg       <= '0;
                        cnt_reg       <= SAMPLE_LOAD;
                    end else begin
                        state_reg     <= ST_IDLE;
                        sample_en_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        dac_reg       <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (!ctrl_en) begin
                        state_reg     <= ST_IDLE;
                        sample_en_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        dac_reg       <= '0;
                    end else if (cnt_done) begin
                        state_reg     <= ST_CONVERT;
                        sample_en_reg <= 1'b0;
                        idx_reg       <= IDX_MSB;
                        result_reg    <= '0;
                        dac_reg       <= MSB_MASK;
                        cnt_reg       <= SETTLE_LOAD;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_CONVERT: begin
                    if (!ctrl_en) begin
                        state_reg     <= ST_IDLE;
                        sample_en_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        dac_reg       <= '0;
                    end else if (cnt_done) begin
                        // Comparator is sampled on the last settle cycle of each trial.
                        result_reg <= result_next;
                        if (last_bit) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            eoc_reg   <= 1'b1;
                            data_reg  <= data_next;
                            dac_reg   <= '0;
                        end else begin
                            idx_reg <= idx_reg - IDX_W'(1);
                            dac_reg <= trial_next;
                            cnt_reg <= SETTLE_LOAD;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    sample_en_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    dac_reg       <= '0;
                end
            endcase
        end
    end

    assign sample_en      = sample_en_reg;
    assign dac_code       = dac_reg;
    assign adc_data_out   = data_reg;
    assign adc_busy_out   = busy_reg;
    assign adc_eoc_pulse  = eoc_reg;
    assign hw_clear_start = clear_reg;

endmodule
